// File: rtl/sha_test_seq.sv
// Self-test sequencer: streams stored vectors into a hash core and scores each result
// against the stored expected hash, with a response watchdog.
//
// state | meaning
// IDLE  | waiting for start, results held
// FETCH | address vector memory, wait for room in the expected-hash FIFO
// ISSUE | capture message, push expected hash, pulse core_enable next cycle
// DRAIN | all vectors issued, waiting for the remaining results
// DONE  | run finished or watchdog expired, results held
module sha_test_seq #(
    parameter int NV   = 16,
    parameter int DW   = 512,
    parameter int HW   = 256,
    parameter int OUTS = 1,
    parameter int TMO  = 1024,
    localparam int AW  = (NV > 1) ? $clog2(NV) : 1,
    localparam int CW  = $clog2(NV + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    input  logic [HW-1:0] mem_hash,
    output logic [DW-1:0] core_data,
    output logic          core_enable,
    input  logic [HW-1:0] core_hash,
    input  logic          core_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt,
    output logic [AW-1:0] first_fail_idx,
    output logic          timeout
);

    localparam int FW = $clog2(OUTS + 1);
    localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int WW = $clog2(TMO);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] fifo_mem [OUTS];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [FW-1:0] fifo_cnt;
    logic [AW-1:0] issue_idx;
    logic [CW-1:0] check_idx;
    logic [WW-1:0] wd_left;

    logic run, fifo_empty, pop, push, wd_trip, launch, room, last_issue, match;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTS - 1)) ? '0 : p + PW'(1);
    endfunction

    assign run        = (state == FETCH) || (state == ISSUE) || (state == DRAIN);
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = run && core_ready && !fifo_empty;
    // Watchdog is a down-counter; terminal count hits on the TMO-th stalled cycle.
    assign wd_trip    = run && !fifo_empty && !core_ready && (wd_left == '0);
    assign push       = (state == ISSUE) && !wd_trip;
    assign launch     = start && ((state == IDLE) || (state == DONE));
    assign room       = (fifo_cnt - FW'(pop)) < FW'(OUTS);
    assign last_issue = (issue_idx == AW'(NV - 1));
    assign match      = (core_hash == fifo_mem[rd_ptr]);
    assign mem_addr   = issue_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_nxt = FETCH;
            FETCH:      if (room) state_nxt = ISSUE;
            ISSUE:      state_nxt = last_issue ? DRAIN : FETCH;
            DRAIN:      if (check_idx == CW'(NV)) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (wd_trip) state_nxt = DONE;
        busy = (state != IDLE) && (state != DONE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst && push) fifo_mem[wr_ptr] <= mem_hash;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            core_enable    <= 1'b0;
            core_data      <= '0;
            issue_idx      <= '0;
            check_idx      <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            timeout        <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_cnt       <= '0;
            wd_left        <= WW'(TMO - 1);
        end else begin
            core_enable <= push;
            if (push) core_data <= mem_data;
            if (launch) begin
                issue_idx      <= '0;
                check_idx      <= '0;
                pass_cnt       <= '0;
                fail_cnt       <= '0;
                first_fail_idx <= '0;
                timeout        <= 1'b0;
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                fifo_cnt       <= '0;
                wd_left        <= WW'(TMO - 1);
            end else if (wd_trip) begin
                // Outstanding results are abandoned; counters freeze in DONE.
                timeout  <= 1'b1;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                wd_left  <= WW'(TMO - 1);
            end else begin
                if (push) begin
                    wr_ptr    <= ptr_inc(wr_ptr);
                    issue_idx <= issue_idx + AW'(1);
                end
                if (pop) begin
                    rd_ptr    <= ptr_inc(rd_ptr);
                    check_idx <= check_idx + CW'(1);
                    if (match) begin
                        pass_cnt <= pass_cnt + CW'(1);
                    end else begin
                        fail_cnt <= fail_cnt + CW'(1);
                        if (fail_cnt == '0) first_fail_idx <= check_idx[AW-1:0];
                    end
                end
                if (push && !pop)      fifo_cnt <= fifo_cnt + FW'(1);
                else if (pop && !push) fifo_cnt <= fifo_cnt - FW'(1);
                if (fifo_empty || core_ready) wd_left <= WW'(TMO - 1);
                else                          wd_left <= wd_left - WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sha_test_seq.sv
// Randomized bench for sha_test_seq: vector memory and hash core models, per-run
// expected results queued at launch and scored by a monitor when done rises.
module tb_sha_test_seq;

    localparam int NV = 8, DW = 64, HW = 32, OUTS = 4, TMO = 24;
    localparam int AW = $clog2(NV), CW = $clog2(NV + 1);

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic [HW-1:0] mem_hash = '0;
    logic [DW-1:0] core_data;
    logic          core_enable;
    logic [HW-1:0] core_hash = '0;
    logic          core_ready = 1'b0;
    logic          busy, done, timeout;
    logic [CW-1:0] pass_cnt, fail_cnt;
    logic [AW-1:0] first_fail_idx;

    always #5 clk = ~clk;

    sha_test_seq #(.NV(NV), .DW(DW), .HW(HW), .OUTS(OUTS), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_hash(mem_hash),
        .core_data(core_data), .core_enable(core_enable),
        .core_hash(core_hash), .core_ready(core_ready),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .timeout(timeout)
    );

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {int pass; int fail; int ffi; bit tmo; int en;} exp_t;
    typedef struct {logic [DW-1:0] d; int due;} job_t;

    exp_t          sb[$];
    exp_t          last;
    job_t          jobs[$];
    logic [DW-1:0] msg  [NV];
    logic [HW-1:0] exph [NV];
    logic [AW-1:0] addr_d = '0;
    int            cyc = 0, lat = 3;
    bit            mute = 1'b0, spur = 1'b0;
    int            en_cnt = 0, rdy_cnt = 0, out_cnt = 0, max_out = 0, en_first = -1;

    function automatic logic [HW-1:0] ref_hash(input logic [DW-1:0] m);
        return m[31:0] ^ (m[63:32] * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    // Memory with one-cycle read latency, and an in-order core with fixed latency.
    always begin : models
        job_t j;
        @(posedge clk);
        #2;
        cyc++;
        mem_data   = msg[addr_d];
        mem_hash   = exph[addr_d];
        addr_d     = mem_addr;
        core_ready = 1'b0;
        if (core_enable) begin
            j.d = core_data;
            j.due = cyc + lat;
            jobs.push_back(j);
            en_cnt++;
            out_cnt++;
            if (out_cnt > max_out) max_out = out_cnt;
        end
        if (!mute && jobs.size() > 0 && jobs[0].due <= cyc) begin
            core_ready = 1'b1;
            core_hash  = ref_hash(jobs[0].d);
            void'(jobs.pop_front());
            rdy_cnt++;
            out_cnt--;
            if (en_first < 0) en_first = en_cnt;
        end else if (spur) begin
            core_ready = 1'b1;
            core_hash  = $urandom;
            spur       = 1'b0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   prev_done;
        if (done && !prev_done) begin
            check("sb_pending", 64'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pass_cnt", pass_cnt, e.pass);
                check("fail_cnt", fail_cnt, e.fail);
                check("first_fail_idx", first_fail_idx, e.ffi);
                check("timeout", timeout, e.tmo);
                check("enable_count", en_cnt, e.en);
                check("outstanding_le_outs", 64'(max_out <= OUTS), 1);
            end
        end
        prev_done = done;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_run(input int l, input bit m, input logic [NV-1:0] cmask, input bit to_sb);
        exp_t e;
        lat = l;
        mute = m;
        for (int i = 0; i < NV; i++) begin
            msg[i]  = {$urandom, $urandom};
            exph[i] = ref_hash(msg[i]);
            if (cmask[i]) exph[i] = exph[i] ^ ($urandom | 32'd1);
        end
        e.pass = 0;
        e.fail = 0;
        e.ffi  = 0;
        e.tmo  = m;
        e.en   = m ? ((NV < OUTS) ? NV : OUTS) : NV;
        if (!m) begin
            for (int i = 0; i < NV; i++) begin
                if (exph[i] == ref_hash(msg[i])) e.pass++;
                else begin
                    if (e.fail == 0) e.ffi = i;
                    e.fail++;
                end
            end
        end
        last = e;
        if (to_sb) sb.push_back(e);
    endtask

    task automatic kick();
        start    = 1'b1;
        en_cnt   = 0;
        rdy_cnt  = 0;
        out_cnt  = 0;
        max_out  = 0;
        en_first = -1;
        jobs.delete();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 3000) begin
            tick();
            k++;
        end
        check({name, "_done_in_time"}, done, 1);
        tick(2);
    endtask

    task automatic check_reset(input string name);
        check({name, "_core_enable"}, core_enable, 0);
        check({name, "_core_data"}, core_data, 0);
        check({name, "_mem_addr"}, mem_addr, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_pass_cnt"}, pass_cnt, 0);
        check({name, "_fail_cnt"}, fail_cnt, 0);
        check({name, "_first_fail_idx"}, first_fail_idx, 0);
        check({name, "_timeout"}, timeout, 0);
    endtask

    initial begin : global_limit
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        int k;
        rst = 1'b0;
        tick(3);
        check_reset("por");
        rst = 1'b1;
        tick();

        spur = 1'b1;
        tick(3);
        check("idle_spur_pass", pass_cnt, 0);
        check("idle_spur_fail", fail_cnt, 0);

        load_run(3, 1'b0, '0, 1'b1);
        kick();
        wait_done("clean_lat3");

        load_run(3, 1'b0, NV'(8'b0000_0100), 1'b1);
        kick();
        wait_done("corrupt_v2");

        spur = 1'b1;
        tick(3);
        check("done_spur_pass", pass_cnt, last.pass);
        check("done_spur_fail", fail_cnt, last.fail);
        check("done_spur_done", done, 1);

        load_run(12, 1'b0, '0, 1'b1);
        kick();
        wait_done("lat12");
        check("lat12_enables_before_first_ready", en_first, OUTS);
        check("lat12_max_outstanding", max_out, OUTS);

        load_run(3, 1'b1, '0, 1'b1);
        kick();
        k = 0;
        while (!core_enable && k < 50) begin
            tick();
            k++;
        end
        check("tmo_first_enable", core_enable, 1);
        tick(TMO - 1);
        check("tmo_early_timeout", timeout, 0);
        check("tmo_early_done", done, 0);
        tick();
        check("tmo_timeout", timeout, 1);
        check("tmo_done", done, 1);
        wait_done("tmo");

        load_run(3, 1'b0, NV'($urandom & $urandom), 1'b1);
        kick();
        k = 0;
        while (en_cnt < 3 && k < 200) begin
            tick();
            k++;
        end
        check("midrun_enables_seen", 64'(en_cnt >= 3), 1);
        start = 1'b1;
        tick(2);
        start = 1'b0;
        wait_done("start_ignored");

        load_run(5, 1'b0, '0, 1'b0);
        kick();
        k = 0;
        while (rdy_cnt < 2 && k < 200) begin
            tick();
            k++;
        end
        check("abort_two_retired", 64'(rdy_cnt >= 2), 1);
        rst = 1'b0;
        tick();
        check_reset("abort");
        rst = 1'b1;
        tick(30);
        check("stale_pass", pass_cnt, 0);
        check("stale_fail", fail_cnt, 0);
        check("stale_busy", busy, 0);
        load_run(5, 1'b0, '0, 1'b1);
        kick();
        wait_done("after_abort");

        for (int r = 0; r < 10; r++) begin
            load_run($urandom_range(1, 12), ($urandom_range(0, 5) == 0),
                     NV'($urandom & $urandom & $urandom), 1'b1);
            kick();
            wait_done("random");
            if (r % 3 == 0) begin
                spur = 1'b1;
                tick(3);
                check("random_spur_pass", pass_cnt, last.pass);
                check("random_spur_fail", fail_cnt, last.fail);
            end
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
